// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the NoC crossbar mux and the 1:N egress demux.
package noc_flit_pkg;

   typedef enum logic [1:0] {
      BODY      = 2'b00,
      HEAD      = 2'b01,
      TAIL      = 2'b10,
      HEAD_TAIL = 2'b11
   } flit_type_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } demux_state_t;

   // Widest select vector the one-hot helper accepts; callers zero-extend.
   localparam int ONEHOT_MAX_W = 32;

   function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] vec);
      return (vec != {ONEHOT_MAX_W{1'b0}}) &&
             ((vec & (vec - ONEHOT_MAX_W'(1))) == {ONEHOT_MAX_W{1'b0}});
   endfunction

endpackage

// File: rtl/flit_demux_1xn.sv
// 1:N wormhole flit demux: head latches a one-hot route, the packet follows it
// through one registered output stage. Optional sticky err_o via FLIT_DEMUX_ERR_EN.
module flit_demux_1xn
   import noc_flit_pkg::*;
#(
   parameter int OUT_N  = 5,
   parameter int DATA_W = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        type_i,
   input  logic [OUT_N-1:0]  sel_i,
   input  logic              vld_i,
   output logic              rdy_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        type_o,
   output logic [OUT_N-1:0]  vld_o,
   input  logic [OUT_N-1:0]  rdy_i
`ifdef FLIT_DEMUX_ERR_EN
   ,
   output logic              err_o
`endif
);

   demux_state_t      state_r;
   demux_state_t      state_nxt_s;
   logic [OUT_N-1:0]  route_r;
   logic [OUT_N-1:0]  route_nxt_s;
   logic [OUT_N-1:0]  vld_r;
   logic [DATA_W-1:0] data_r;
   flit_type_t        type_r;
   flit_type_t        flit_s;
   logic [OUT_N-1:0]  fwd_route_s;
   logic              out_fire_s;
   logic              rdy_s;
   logic              in_fire_s;
   logic              sel_ok_s;
   logic              fwd_s;
   logic              err_s;

   // Only the routed output can hold a flit, so other rdy_i bits mask out here.
   assign out_fire_s = |(vld_r & rdy_i);
   assign rdy_s      = (vld_r == {OUT_N{1'b0}}) | out_fire_s;
   assign in_fire_s  = vld_i & rdy_s;
   assign sel_ok_s   = is_onehot(ONEHOT_MAX_W'(sel_i));
   assign flit_s     = flit_type_t'(type_i);

   // Next state, route latch and forward/error decision for the accepted flit.
   always_comb begin
      state_nxt_s = state_r;
      route_nxt_s = route_r;
      fwd_route_s = route_r;
      fwd_s       = 1'b0;
      err_s       = 1'b0;
      if (in_fire_s) begin
         case (state_r)
            IDLE: begin
               case (flit_s)
                  HEAD: begin
                     if (sel_ok_s) begin
                        fwd_s       = 1'b1;
                        fwd_route_s = sel_i;
                        route_nxt_s = sel_i;
                        state_nxt_s = BUSY;
                     end else begin
                        err_s = 1'b1;
                     end
                  end
                  HEAD_TAIL: begin
                     if (sel_ok_s) begin
                        fwd_s       = 1'b1;
                        fwd_route_s = sel_i;
                     end else begin
                        err_s = 1'b1;
                     end
                  end
                  default: err_s = 1'b1;
               endcase
            end
            BUSY: begin
               case (flit_s)
                  BODY:    fwd_s = 1'b1;
                  TAIL: begin
                     fwd_s       = 1'b1;
                     state_nxt_s = IDLE;
                  end
                  default: err_s = 1'b1;
               endcase
            end
            default: state_nxt_s = IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM state, latched route and the single registered output stage.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r <= IDLE;
         route_r <= {OUT_N{1'b0}};
         vld_r   <= {OUT_N{1'b0}};
         data_r  <= {DATA_W{1'b0}};
         type_r  <= BODY;
      end else begin
         state_r <= state_nxt_s;
         route_r <= route_nxt_s;
         if (fwd_s) begin
            vld_r  <= fwd_route_s;
            data_r <= data_i;
            type_r <= flit_s;
         end else if (out_fire_s) begin
            vld_r <= {OUT_N{1'b0}};
         end else begin
            vld_r <= vld_r;
         end
      end
   end

   assign rdy_o  = rdy_s;
   assign vld_o  = vld_r;
   assign data_o = data_r;
   assign type_o = type_r;

`ifdef FLIT_DEMUX_ERR_EN
   logic err_r;

   // Sticky protocol-error flag, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_r <= 1'b0;
      end else if (err_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign err_o = err_r;
`else
   wire unused_err_s = err_s;
`endif

endmodule

// File: tb/tb_flit_demux_1xn.sv
// Self-checking bench for flit_demux_1xn (OUT_N=4, DATA_W=8): vector table plus
// hand sequences, checked against an expected-flit queue.
module tb_flit_demux_1xn;
   import noc_flit_pkg::*;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_ni;
   logic [W-1:0] data_i;
   logic [1:0]   type_i;
   logic [N-1:0] sel_i;
   logic         vld_i;
   logic         rdy_o;
   logic [W-1:0] data_o;
   logic [1:0]   type_o;
   logic [N-1:0] vld_o;
   logic [N-1:0] rdy_i;
`ifdef FLIT_DEMUX_ERR_EN
   logic         err_o;
`endif

   always #5 clk = ~clk;

   flit_demux_1xn #(.OUT_N(N), .DATA_W(W)) dut (
      .clk_i (clk),
      .rst_ni(rst_ni),
      .data_i(data_i),
      .type_i(type_i),
      .sel_i (sel_i),
      .vld_i (vld_i),
      .rdy_o (rdy_o),
      .data_o(data_o),
      .type_o(type_o),
      .vld_o (vld_o),
      .rdy_i (rdy_i)
`ifdef FLIT_DEMUX_ERR_EN
      ,
      .err_o (err_o)
`endif
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic [1:0]   t;
      logic [N-1:0] route;
   } exp_t;

   typedef struct {
      logic [1:0]   t;
      logic [W-1:0] d;
      logic [N-1:0] sel;
      logic         fwd;
      logic [N-1:0] route;
   } vec_t;

   exp_t q[$];
   vec_t vecs[14];
   int   total = 0;
   int   bad   = 0;
   logic err_exp = 1'b0;
   logic fired;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, check outputs against the queue model, update it.
   task automatic step(input logic rst, input logic v, input logic [1:0] t,
                       input logic [W-1:0] d, input logic [N-1:0] s,
                       input logic [N-1:0] r, input logic fwd,
                       input logic [N-1:0] route, output logic f);
      exp_t head;
      logic busy, exp_fire, exp_rdy;
      rst_ni = rst; vld_i = v; type_i = t; data_i = d; sel_i = s; rdy_i = r;
      #1;
      busy     = (q.size() != 0);
      head     = busy ? q[0] : exp_t'(0);
      exp_fire = busy && ((head.route & r) != 4'b0000);
      exp_rdy  = !busy || exp_fire;
      chk("vld_o", 32'(vld_o), 32'(head.route));
      if (busy) begin
         chk("data_o", 32'(data_o), 32'(head.d));
         chk("type_o", 32'(type_o), 32'(head.t));
      end
      chk("rdy_o", 32'(rdy_o), 32'(exp_rdy));
`ifdef FLIT_DEMUX_ERR_EN
      chk("err_o", 32'(err_o), 32'(err_exp));
`endif
      f = v && exp_rdy;
      if (exp_fire) void'(q.pop_front());
      if (!rst) begin
         q.delete();
         err_exp = 1'b0;
      end else if (f) begin
         if (fwd) q.push_back(exp_t'({d, t, route}));
         else     err_exp = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [N-1:0] r);
      logic f;
      step(1'b1, 1'b0, 2'b00, 8'h00, 4'b0000, r, 1'b0, 4'b0000, f);
   endtask

   task automatic send(input vec_t vv);
      logic f;
      int   n;
      f = 1'b0;
      n = 0;
      while (!f && n < 20) begin
         step(1'b1, 1'b1, vv.t, vv.d, vv.sel, 4'b1111, vv.fwd, vv.route, f);
         n++;
      end
      chk("send_accepted", 32'(f), 32'd1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{2'b01, 8'hA1, 4'b0100, 1'b1, 4'b0100};
      vecs[1]  = '{2'b00, 8'hB2, 4'b0001, 1'b1, 4'b0100};
      vecs[2]  = '{2'b10, 8'hC3, 4'b0001, 1'b1, 4'b0100};
      vecs[3]  = '{2'b11, 8'h11, 4'b1000, 1'b1, 4'b1000};
      vecs[4]  = '{2'b01, 8'h22, 4'b0001, 1'b1, 4'b0001};
      vecs[5]  = '{2'b10, 8'h23, 4'b0000, 1'b1, 4'b0001};
      vecs[6]  = '{2'b00, 8'h33, 4'b0001, 1'b0, 4'b0000};
      vecs[7]  = '{2'b01, 8'h44, 4'b0110, 1'b0, 4'b0000};
      vecs[8]  = '{2'b11, 8'h55, 4'b0000, 1'b0, 4'b0000};
      vecs[9]  = '{2'b01, 8'h66, 4'b0010, 1'b1, 4'b0010};
      vecs[10] = '{2'b01, 8'h77, 4'b0001, 1'b0, 4'b0000};
      vecs[11] = '{2'b11, 8'h78, 4'b1000, 1'b0, 4'b0000};
      vecs[12] = '{2'b10, 8'h79, 4'b1000, 1'b1, 4'b0010};
      vecs[13] = '{2'b10, 8'h7A, 4'b0100, 1'b0, 4'b0000};

      rst_ni = 1'b0; vld_i = 1'b0; type_i = 2'b00; data_i = 8'h00;
      sel_i = 4'b0000; rdy_i = 4'b1111;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_vld_o", 32'(vld_o), 32'd0);
      chk("rst_data_o", 32'(data_o), 32'd0);
      chk("rst_type_o", 32'(type_o), 32'd0);
      chk("rst_rdy_o", 32'(rdy_o), 32'd1);
`ifdef FLIT_DEMUX_ERR_EN
      chk("rst_err_o", 32'(err_o), 32'd0);
`endif
      @(negedge clk);

      for (int i = 0; i < 14; i++) send(vecs[i]);
      idle(4'b1111);
      idle(4'b1111);

      // Stall on the routed output while unrelated ready bits stay high.
      step(1'b1, 1'b1, 2'b01, 8'hA1, 4'b0100, 4'b1111, 1'b1, 4'b0100, fired);
      step(1'b1, 1'b1, 2'b00, 8'hB2, 4'b0001, 4'b1111, 1'b1, 4'b0100, fired);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 2'b10, 8'hC3, 4'b0001, 4'b1011, 1'b1, 4'b0100, fired);
         chk("stall_no_accept", 32'(fired), 32'd0);
      end
      step(1'b1, 1'b1, 2'b10, 8'hC3, 4'b0001, 4'b1111, 1'b1, 4'b0100, fired);
      chk("release_accept", 32'(fired), 32'd1);
      idle(4'b1111);
      idle(4'b1111);
      idle(4'b1111);

      // Reset right after a head is accepted; the following body is an orphan.
      step(1'b1, 1'b1, 2'b01, 8'h88, 4'b0010, 4'b1111, 1'b1, 4'b0010, fired);
      step(1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b1111, 1'b0, 4'b0000, fired);
      step(1'b1, 1'b1, 2'b00, 8'h99, 4'b0010, 4'b1111, 1'b0, 4'b0000, fired);
      idle(4'b1111);
      idle(4'b1111);

      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
